// File: rtl/act_row_collector.sv
// act_row_collector: re-aligns skewed per-lane activations into whole rows
// and writes them to the output buffer over a valid/ready port.
module act_row_collector #(
  parameter int LANES  = 16,
  parameter int DW     = 20,
  parameter int NSLOT  = 4,
  parameter int ADDR_W = 10,
  parameter int ROW_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ROW_W-1:0]      tile_rows,
  input  logic [LANES*DW-1:0]   act_in,
  input  logic [LANES-1:0]      act_in_valid,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [ADDR_W-1:0]     wb_addr,
  output logic [LANES*DW-1:0]   wb_data,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf_err
);

  localparam int SW = $clog2(NSLOT);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [ROW_W-1:0]  rows_q;
  logic [ROW_W-1:0]  rows_out, rows_out_nxt;
  logic [ROW_W-1:0]  lane_cnt [LANES];
  logic [ROW_W-1:0]  lane_cnt_nxt [LANES];
  logic [LANES-1:0]  fill [NSLOT];
  logic [LANES-1:0]  fill_nxt [NSLOT];
  logic [DW-1:0]     slot [NSLOT][LANES];
  logic [DW-1:0]     slot_nxt [NSLOT][LANES];
  logic [SW-1:0]     head, head_nxt, tgt;
  logic              hs, ovf_set, load;

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Slot/counter next state: drain of the head slot, then lane writes
  // (a write into the slot being drained wins over the clear).
  always_comb begin
    hs           = wb_valid & wb_ready;
    head_nxt     = head + SW'(hs);
    rows_out_nxt = rows_out + ROW_W'(hs);
    fill_nxt     = fill;
    slot_nxt     = slot;
    lane_cnt_nxt = lane_cnt;
    ovf_set      = 1'b0;
    tgt          = '0;
    if (hs) fill_nxt[head] = '0;
    if (state == RUN) begin
      for (int i = 0; i < LANES; i++) begin
        if (act_in_valid[i]) begin
          tgt = lane_cnt[i][SW-1:0];
          if (lane_cnt[i] >= rows_q) begin
            ovf_set = 1'b1;
          end else if (fill[tgt][i] && !(hs && tgt == head)) begin
            ovf_set = 1'b1;
          end else begin
            fill_nxt[tgt][i] = 1'b1;
            slot_nxt[tgt][i] = act_in[i*DW +: DW];
            lane_cnt_nxt[i]  = lane_cnt[i] + ROW_W'(1);
          end
        end
      end
    end
    load = (state == RUN) && (!wb_valid || hs) && (&fill_nxt[head_nxt]);
  end

  // Tile control: finish as soon as the last row is accepted.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (rows_out_nxt == rows_q) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Slot buffer, counters and the output row register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q   <= '0;
      rows_q   <= '0;
      rows_out <= '0;
      head     <= '0;
      ovf_err  <= 1'b0;
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      for (int s = 0; s < NSLOT; s++) begin
        fill[s] <= '0;
        for (int l = 0; l < LANES; l++) slot[s][l] <= '0;
      end
      for (int l = 0; l < LANES; l++) lane_cnt[l] <= '0;
    end else if (state == IDLE && start) begin
      base_q   <= base_addr;
      rows_q   <= tile_rows;
      rows_out <= '0;
      head     <= '0;
      ovf_err  <= 1'b0;
      wb_valid <= 1'b0;
      for (int s = 0; s < NSLOT; s++) fill[s] <= '0;
      for (int l = 0; l < LANES; l++) lane_cnt[l] <= '0;
    end else begin
      fill     <= fill_nxt;
      slot     <= slot_nxt;
      lane_cnt <= lane_cnt_nxt;
      head     <= head_nxt;
      rows_out <= rows_out_nxt;
      if (ovf_set) ovf_err <= 1'b1;
      if (load) begin
        wb_valid <= 1'b1;
        wb_addr  <= base_q + ADDR_W'(rows_out_nxt);
        for (int l = 0; l < LANES; l++)
          wb_data[l*DW +: DW] <= slot_nxt[head_nxt][l];
      end else if (hs) begin
        wb_valid <= 1'b0;
      end
    end
  end

endmodule
